// File: rtl/rob_pkg.sv
// PID arithmetic shared by the transmit window and the receive-side reorder buffer.
// Both ends must agree on the modular offset and the slot mapping.
package rob_pkg;

  localparam int unsigned WORD_LEN_DEF = 8;
  localparam int unsigned PID_LEN_DEF  = 8;
  localparam int unsigned WIN_SIZE_DEF = 8;
  localparam int unsigned SLOT_LEN_DEF = $clog2(WIN_SIZE_DEF);

  function automatic logic [31:0] len_mask(input int unsigned len);
    return (len >= 32) ? '1 : ((32'd1 << len) - 32'd1);
  endfunction

  // Distance from base to pid modulo 2^pid_len; wrap needs no special case.
  function automatic logic [31:0] pid_off(input logic [31:0] pid, input logic [31:0] base,
                                          input int unsigned pid_len);
    return (pid - base) & len_mask(pid_len);
  endfunction

  function automatic logic [31:0] pid_slot(input logic [31:0] pid, input int unsigned slot_len);
    return pid & len_mask(slot_len);
  endfunction

endpackage

// File: rtl/rob_tx_window_if.sv
// Handshake bundle between the transmit window and its source, channel and ack return.
interface rob_tx_window_if #(
  parameter int p_WORD_LEN = rob_pkg::WORD_LEN_DEF,
  parameter int p_PID_LEN  = rob_pkg::PID_LEN_DEF
);

  logic [p_WORD_LEN-1:0] i_inp_data;
  logic                  i_inp_en;
  logic                  o_inp_rdy;
  logic [p_PID_LEN-1:0]  o_out_pid;
  logic [p_WORD_LEN-1:0] o_out_data;
  logic                  o_out_valid;
  logic                  i_out_rdy;
  logic [p_PID_LEN-1:0]  i_ack_pid;
  logic                  i_ack_en;
  logic                  o_ack_ok;

  modport master (
    output i_inp_data, i_inp_en, i_out_rdy, i_ack_pid, i_ack_en,
    input  o_inp_rdy, o_out_pid, o_out_data, o_out_valid, o_ack_ok
  );

  modport slave (
    input  i_inp_data, i_inp_en, i_out_rdy, i_ack_pid, i_ack_en,
    output o_inp_rdy, o_out_pid, o_out_data, o_out_valid, o_ack_ok
  );

endinterface

// File: rtl/rob_retx_timer.sv
// Retransmit timer: counts enabled cycles and pulses o_fire on the p_TIMEOUT-th one.
module rob_retx_timer #(
  parameter int p_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_fire
);

  localparam int CNT_W = $clog2(p_TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // A clear in the terminal cycle suppresses the fire.
  assign o_fire = i_enable & ~i_clear & (r_cnt == CNT_W'(p_TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable || o_fire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rob_tx_window.sv
// Transmit sliding window: numbers packets, holds them until acked and
// retransmits the unacked ones when the base stops moving for p_TIMEOUT cycles.
module rob_tx_window
  import rob_pkg::*;
#(
  parameter int p_WORD_LEN = WORD_LEN_DEF,
  parameter int p_PID_LEN  = PID_LEN_DEF,
  parameter int p_WIN_SIZE = WIN_SIZE_DEF,
  parameter int p_TIMEOUT  = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [p_PID_LEN-1:0] i_reset_pid,
  rob_tx_window_if.slave       bus,
  output logic                 o_timeout,
  output logic [p_PID_LEN-1:0] o_min_pid,
  output logic [p_PID_LEN-1:0] o_next_pid,
  output logic                 o_empty
);

  localparam int SLOT_W = $clog2(p_WIN_SIZE);

  typedef logic [p_PID_LEN-1:0] pid_t;
  typedef logic [SLOT_W-1:0]    slot_t;

  function automatic pid_t off(input pid_t p, input pid_t base);
    return pid_t'(pid_off(32'(p), 32'(base), p_PID_LEN));
  endfunction

  function automatic slot_t slot(input pid_t p);
    return slot_t'(pid_slot(32'(p), SLOT_W));
  endfunction

  pid_t                  r_base, r_tx, r_next;
  logic [p_WIN_SIZE-1:0] r_valid, r_acked;
  logic [p_WORD_LEN-1:0] r_mem [p_WIN_SIZE];
  logic                  r_ack_ok, r_timeout;

  pid_t  count;
  slot_t tx_slot, base_slot, next_slot, ack_slot;
  logic  inp_rdy, accept, retire, tx_pend, out_valid, tx_adv, ack_hit;
  logic  tmr_enable, tmr_clear, tmr_fire;

  assign count     = off(r_next, r_base);
  assign tx_slot   = slot(r_tx);
  assign base_slot = slot(r_base);
  assign next_slot = slot(r_next);
  assign ack_slot  = slot(bus.i_ack_pid);

  // Ready uses the pre-retire count, so the accept slot never collides with the retiring one.
  assign inp_rdy   = count < pid_t'(p_WIN_SIZE);
  assign accept    = bus.i_inp_en & inp_rdy;
  assign retire    = (count != '0) & r_acked[base_slot];
  assign tx_pend   = r_tx != r_next;
  assign out_valid = tx_pend & ~r_acked[tx_slot];
  // An already-acked slot is skipped with a one-cycle bubble; this also walks r_tx past a retiring base.
  assign tx_adv    = tx_pend & (r_acked[tx_slot] | bus.i_out_rdy);
  assign ack_hit   = bus.i_ack_en & (off(bus.i_ack_pid, r_base) < count);

  assign tmr_enable = r_base != r_tx;
  assign tmr_clear  = retire | ~tmr_enable;

  rob_retx_timer #(
    .p_TIMEOUT (p_TIMEOUT)
  ) u_retx_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_enable  (tmr_enable),
    .i_clear   (tmr_clear),
    .o_fire    (tmr_fire)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_base    <= i_reset_pid;
      r_tx      <= i_reset_pid;
      r_next    <= i_reset_pid;
      r_ack_ok  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (retire) r_base <= r_base + pid_t'(1);
      if (accept) r_next <= r_next + pid_t'(1);
      if (tmr_fire)    r_tx <= r_base;
      else if (tx_adv) r_tx <= r_tx + pid_t'(1);
      r_ack_ok  <= ack_hit;
      r_timeout <= tmr_fire;
    end
  end

  // Retire clears after the ack sets, so a duplicate ack of the retiring base cannot resurrect it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= '0;
      r_acked <= '0;
    end else begin
      if (accept) begin
        r_valid[next_slot] <= 1'b1;
        r_acked[next_slot] <= 1'b0;
      end
      if (ack_hit) r_acked[ack_slot] <= 1'b1;
      if (retire) begin
        r_valid[base_slot] <= 1'b0;
        r_acked[base_slot] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) r_mem[next_slot] <= bus.i_inp_data;
  end

  assign bus.o_inp_rdy   = inp_rdy;
  assign bus.o_out_valid = out_valid;
  assign bus.o_out_pid   = r_tx;
  assign bus.o_out_data  = (out_valid && r_valid[tx_slot]) ? r_mem[tx_slot] : '1;
  assign bus.o_ack_ok    = r_ack_ok;
  assign o_timeout       = r_timeout;
  assign o_min_pid       = r_base;
  assign o_next_pid      = r_next;
  assign o_empty         = r_base == r_next;

endmodule
